rs_err_fmt: RTL and testbench

//  Reed-Solomon error formatter, GF(2^8), primitive poly 0x11D. Sits after Chien/Forney numerator stage.
//  Per error it takes locator X, Forney numerator num and denominator den.

---
 rtl/rs_err_fmt.sv | 125 ++++++++++++
 tb/tb_rs_err_fmt.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_err_fmt.sv
// Reed-Solomon error formatter, GF(2^8) with primitive polynomial 0x11D.
// Per error tuple (locator X, Forney numerator, Forney denominator) it looks up
// den^-1 and log(X) through the shared rsROM port, then produces the error
// magnitude num*den^-1 and the absolute byte position N_BYTES-1-log(X).
module rs_err_fmt #(
    parameter int N_BYTES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_loc,
    input  logic [7:0] in_num,
    input  logic [7:0] in_den,
    output logic [8:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_pos,
    output logic [7:0] out_mag,
    output logic       out_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INV  = 2'd1,
        LOG  = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Highest legal byte index; log values above it fall outside the codeword.
    localparam logic [7:0] LAST_POS = 8'(N_BYTES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] loc_r;
    logic [7:0] num_r;
    logic [7:0] den_r;
    logic [7:0] inv_r;
    logic [7:0] pos_c;
    logic [7:0] mag_c;
    logic       err_c;

    // GF(2^8) multiply: shift-and-add with reduction by x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
        end
        return p;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: one ROM lookup per state, then hold until downstream takes the result.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = INV;
            INV:     state_nxt = LOG;
            LOG:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    // ROM address follows the state being entered, so it is stable for the whole lookup cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= 9'd0;
        end else begin
            case (state_nxt)
                INV:     rom_addr <= {1'b0, in_den};
                LOG:     rom_addr <= {1'b1, loc_r};
                default: rom_addr <= 9'd0;
            endcase
        end
    end

    // Tuple capture on accept and inverse capture at the end of the INV lookup.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            loc_r <= in_loc;
            num_r <= in_num;
            den_r <= in_den;
        end
        if (state == INV) inv_r <= rom_q;
    end

    // Result formation during LOG, where rom_q carries log(X); log(0) from the ROM is never used.
    always_comb begin
        pos_c = 8'd0;
        mag_c = 8'd0;
        err_c = 1'b0;
        if (den_r == 8'd0) err_c = 1'b1;
        else               mag_c = gf_mul(num_r, inv_r);
        if (loc_r == 8'd0 || rom_q > LAST_POS) err_c = 1'b1;
        else                                   pos_c = LAST_POS - rom_q;
    end

    // Output registers: loaded once leaving LOG, then held through OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_pos <= 8'd0;
            out_mag <= 8'd0;
            out_err <= 1'b0;
        end else if (state == LOG) begin
            out_pos <= pos_c;
            out_mag <= mag_c;
            out_err <= err_c;
        end
    end

endmodule

// File: tb/tb_rs_err_fmt.sv
// Bench for rs_err_fmt: two instances (N_BYTES=255 and N_BYTES=204) share the
// upstream/downstream controls, each with its own model ROM. Expected tuples are
// queued at send time and compared by a monitor when a result is handed off.
module tb_rs_err_fmt;

    typedef struct packed {
        logic [7:0] pos;
        logic [7:0] mag;
        logic       err;
    } res_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_loc;
    logic [7:0] in_num;
    logic [7:0] in_den;
    logic       out_ready;

    logic       a_in_ready, b_in_ready;
    logic [8:0] a_rom_addr, b_rom_addr;
    logic [7:0] a_rom_q, b_rom_q;
    logic       a_out_valid, b_out_valid;
    logic [7:0] a_out_pos, b_out_pos;
    logic [7:0] a_out_mag, b_out_mag;
    logic       a_out_err, b_out_err;

    logic [7:0] rom [512];
    int         exp_t [255];
    int         log_t [256];

    res_t q_a[$];
    res_t q_b[$];
    res_t ea, eb;

    int tests = 0;
    int fails = 0;

    rs_err_fmt #(.N_BYTES(255)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_loc(in_loc), .in_num(in_num), .in_den(in_den),
        .rom_addr(a_rom_addr), .rom_q(a_rom_q),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pos(a_out_pos), .out_mag(a_out_mag), .out_err(a_out_err)
    );

    rs_err_fmt #(.N_BYTES(204)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_loc(in_loc), .in_num(in_num), .in_den(in_den),
        .rom_addr(b_rom_addr), .rom_q(b_rom_q),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pos(b_out_pos), .out_mag(b_out_mag), .out_err(b_out_err)
    );

    assign a_rom_q = rom[a_rom_addr];
    assign b_rom_q = rom[b_rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result from log/antilog tables.
    function automatic res_t model(input logic [7:0] l, input logic [7:0] n,
                                   input logic [7:0] d, input int nb);
        res_t r;
        int   lg;
        r = '0;
        if (d == 8'd0) r.err = 1'b1;
        else if (n != 8'd0) r.mag = 8'(exp_t[(log_t[n] + 255 - log_t[d]) % 255]);
        if (l == 8'd0) begin
            r.err = 1'b1;
        end else begin
            lg = log_t[l];
            if (lg > nb - 1) r.err = 1'b1;
            else             r.pos = 8'(nb - 1 - lg);
        end
        return r;
    endfunction

    // Scoreboard monitor: a handoff happens at the next rising edge when valid&ready at the falling edge.
    always @(negedge clk) begin
        if (!rst && a_out_valid && out_ready) begin
            tests++;
            if (q_a.size() == 0 || q_b.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected got pos=%0d mag=%h err=%0b want no output",
                         a_out_pos, a_out_mag, a_out_err);
            end else begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                if ({a_out_pos, a_out_mag, a_out_err} !== ea) begin
                    fails++;
                    $display("FAIL sb_n255 got pos=%0d mag=%h err=%0b want pos=%0d mag=%h err=%0b",
                             a_out_pos, a_out_mag, a_out_err, ea.pos, ea.mag, ea.err);
                end
                tests++;
                if ({b_out_valid, b_out_pos, b_out_mag, b_out_err} !== {1'b1, eb}) begin
                    fails++;
                    $display("FAIL sb_n204 got v=%0b pos=%0d mag=%h err=%0b want v=1 pos=%0d mag=%h err=%0b",
                             b_out_valid, b_out_pos, b_out_mag, b_out_err, eb.pos, eb.mag, eb.err);
                end
            end
        end
    end

    task automatic send(input logic [7:0] l, input logic [7:0] n, input logic [7:0] d,
                        input bit expect_out);
        int k = 0;
        while (!a_in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (!a_in_ready) begin
            fails++;
            $display("FAIL send_ready got in_ready=%0b want 1", a_in_ready);
        end
        in_valid = 1'b1;
        in_loc   = l;
        in_num   = n;
        in_den   = d;
        if (expect_out) begin
            q_a.push_back(model(l, n, d, 255));
            q_b.push_back(model(l, n, d, 204));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!a_out_valid && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (!a_out_valid) begin
            fails++;
            $display("FAIL wait_valid got out_valid=0 want 1 within 20 cycles");
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_loc = 8'd0; in_num = 8'd0; in_den = 8'd0;
        #12;
        tests++;
        if ({a_in_ready, a_out_valid, a_out_pos, a_out_mag, a_out_err, a_rom_addr} !==
            {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 9'd0}) begin
            fails++;
            $display("FAIL reset_state got rdy=%0b v=%0b pos=%0d mag=%h err=%0b addr=%0d want 1 0 0 00 0 0",
                     a_in_ready, a_out_valid, a_out_pos, a_out_mag, a_out_err, a_rom_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        send(8'h02, 8'h01, 8'h02, 1'b1);
        tests++;
        if (a_rom_addr !== 9'h002 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL inv_addr got addr=%h v=%0b want 002 0", a_rom_addr, a_out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (a_rom_addr !== 9'h102 || a_out_valid !== 1'b0) begin
            fails++;
            $display("FAIL log_addr got addr=%h v=%0b want 102 0", a_rom_addr, a_out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if ({a_out_valid, a_out_pos, a_out_mag, a_out_err, a_rom_addr} !==
            {1'b1, 8'd253, 8'h8E, 1'b0, 9'd0}) begin
            fails++;
            $display("FAIL basic_latency got v=%0b pos=%0d mag=%h err=%0b addr=%0d want 1 253 8e 0 0",
                     a_out_valid, a_out_pos, a_out_mag, a_out_err, a_rom_addr);
        end
        handshake();
        send(8'h01, 8'h03, 8'h03, 1'b1);
        wait_valid();
        tests++;
        if ({a_out_pos, a_out_mag, a_out_err} !== {8'd254, 8'h01, 1'b0}) begin
            fails++;
            $display("FAIL basic_loc1 got pos=%0d mag=%h err=%0b want 254 01 0",
                     a_out_pos, a_out_mag, a_out_err);
        end
        handshake();
    endtask

    task automatic test_position();
        send(8'hDD, 8'h01, 8'h01, 1'b1);
        wait_valid();
        tests++;
        if ({b_out_pos, b_out_err, a_out_pos, a_out_err} !== {8'd0, 1'b1, 8'd50, 1'b0}) begin
            fails++;
            $display("FAIL pos_outside got n204 pos=%0d err=%0b n255 pos=%0d err=%0b want 0 1 50 0",
                     b_out_pos, b_out_err, a_out_pos, a_out_err);
        end
        handshake();
        send(8'hFF, 8'h01, 8'h01, 1'b1);
        wait_valid();
        tests++;
        if ({b_out_pos, b_out_err} !== {8'd28, 1'b0}) begin
            fails++;
            $display("FAIL pos_inside got pos=%0d err=%0b want 28 0", b_out_pos, b_out_err);
        end
        handshake();
    endtask

    task automatic test_errors();
        send(8'h00, 8'h07, 8'h05, 1'b1);
        wait_valid();
        tests++;
        if ({a_out_pos, a_out_err} !== {8'd0, 1'b1}) begin
            fails++;
            $display("FAIL loc_zero got pos=%0d err=%0b want 0 1", a_out_pos, a_out_err);
        end
        handshake();
        send(8'h05, 8'h07, 8'h00, 1'b1);
        wait_valid();
        tests++;
        if ({a_out_mag, a_out_err} !== {8'd0, 1'b1}) begin
            fails++;
            $display("FAIL den_zero got mag=%h err=%0b want 00 1", a_out_mag, a_out_err);
        end
        handshake();
        send(8'h03, 8'h00, 8'h05, 1'b1);
        wait_valid();
        tests++;
        if ({a_out_mag, a_out_err} !== {8'd0, 1'b0}) begin
            fails++;
            $display("FAIL num_zero got mag=%h err=%0b want 00 0", a_out_mag, a_out_err);
        end
        handshake();
    endtask

    task automatic test_stall();
        res_t snap;
        send(8'h10, 8'h20, 8'h30, 1'b1);
        wait_valid();
        snap     = {a_out_pos, a_out_mag, a_out_err};
        in_valid = 1'b1;
        in_loc   = 8'h40;
        in_num   = 8'h11;
        in_den   = 8'h22;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({a_out_valid, a_in_ready, a_out_pos, a_out_mag, a_out_err} !== {1'b1, 1'b0, snap}) begin
                fails++;
                $display("FAIL stall_hold cycle %0d got v=%0b rdy=%0b pos=%0d mag=%h err=%0b want 1 0 %0d %h %0b",
                         i, a_out_valid, a_in_ready, a_out_pos, a_out_mag, a_out_err,
                         snap.pos, snap.mag, snap.err);
            end
        end
        q_a.push_back(model(8'h40, 8'h11, 8'h22, 255));
        q_b.push_back(model(8'h40, 8'h11, 8'h22, 204));
        handshake();
        tests++;
        if ({a_in_ready, a_out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL stall_release got rdy=%0b v=%0b want 1 0", a_in_ready, a_out_valid);
        end
        @(posedge clk); #1;
        tests++;
        if (a_in_ready !== 1'b0 || a_rom_addr !== 9'h022) begin
            fails++;
            $display("FAIL held_accept got rdy=%0b addr=%h want 0 022", a_in_ready, a_rom_addr);
        end
        in_valid = 1'b0;
        wait_valid();
        handshake();
    endtask

    task automatic test_reset_mid();
        send(8'h02, 8'h01, 8'h02, 1'b0);
        @(posedge clk); #1;
        tests++;
        if (a_rom_addr !== 9'h102) begin
            fails++;
            $display("FAIL mid_in_log got addr=%h want 102", a_rom_addr);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({a_out_valid, a_in_ready, a_rom_addr, b_out_valid, b_in_ready, b_rom_addr} !==
            {1'b0, 1'b1, 9'd0, 1'b0, 1'b1, 9'd0}) begin
            fails++;
            $display("FAIL mid_reset got v=%0b rdy=%0b addr=%0d want 0 1 0",
                     a_out_valid, a_in_ready, a_rom_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h02, 8'h01, 8'h02, 1'b1);
        wait_valid();
        tests++;
        if ({a_out_pos, a_out_mag, a_out_err} !== {8'd253, 8'h8E, 1'b0}) begin
            fails++;
            $display("FAIL after_reset got pos=%0d mag=%h err=%0b want 253 8e 0",
                     a_out_pos, a_out_mag, a_out_err);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), 1'b1);
        end
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        log_t[0] = 255;
        for (int a = 0; a < 256; a++) begin
            rom[a]       = (a == 0) ? 8'd0 : 8'(exp_t[(255 - log_t[a]) % 255]);
            rom[256 + a] = 8'(log_t[a]);
        end

        test_reset();
        test_basic();
        test_position();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();

        repeat (4) @(posedge clk);
        #1;
        tests++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending want 0", q_a.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
